ibex_rvfi_trace_buffer: RTL and testbench
=========================================

Name: ibex_rvfi_trace_buffer

Overview:
- Consumes the RVFI retirement stream from ibex_top and buffers each retired instruction as a record.
- Serialises each record into a variable-length 32-bit word stream with valid/ready handshake, for an off-core trace sink (DMA, debug port, TB monitor).
- Sits beside the text tracer as the hardware trace path.
- If the FIFO overflows, records are dropped and counted; the count is reported in-band.

Parameters:
- Depth, 8, number of record FIFO entries; power of two, >=2.
- SyncNibble, 4'hA, value placed in header bits [31:28].

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- rvfi_valid  in  1  retirement strobe
- rvfi_insn  in  32  retired instruction
- rvfi_trap  in  1  trap flag
- rvfi_halt  in  1  halt flag
- rvfi_intr  in  1  first instruction of a trap handler
- rvfi_pc_rdata  in  32  PC of the retired instruction
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- rvfi_mem_addr  in  32  memory address
- rvfi_mem_rmask  in  4  load byte mask
- rvfi_mem_wmask  in  4  store byte mask
- trace_valid_o  out  1  output word valid
- trace_ready_i  in  1  sink ready
- trace_data_o  out  32  output word
- trace_last_o  out  1  final word of the packet
- fifo_level_o  out  $clog2(Depth)+1  occupied entries
- drop_total_o  out  16  saturating lifetime drop count

Behaviour:
- Reset (async, rst_ni=0):
  - FIFO empty; FSM IDLE; drop counters 0.
  - All outputs 0.
  - An in-flight packet is abandoned and is not resumed.
- Push:
  - Occurs when rvfi_valid=1 and the FIFO is not full.
  - Record = {trap, intr, halt, has_rd=(rd_addr!=0), has_mem=(rmask|wmask)!=0, is_store=(wmask!=0), rd_addr, pc, insn, rd_wdata, mem_addr}.
- Drop:
  - Occurs when rvfi_valid=1 and the FIFO is full.
  - pending_drops increments, saturating at 16'hFFFF.
  - drop_total_o increments, saturating.
- Push/pop in the same cycle while full: the pop frees the slot and the push is accepted, with no drop. The full test uses the post-pop level.
- FSM states: IDLE, HDR, PC, INSN, RD, MEM.
- IDLE:
  - If the FIFO is non-empty: pop into the record register, latch pending_drops into the header, clear pending_drops, then go to HDR.
  - A drop in the same cycle sets pending_drops to 1, so it is reported in the next header.
- Header word:
  - [31:28] SyncNibble
  - [27] trap, [26] intr, [25] halt
  - [24] has_rd, [23] has_mem, [22] is_store
  - [21:17] rd_addr
  - [16] drops!=0
  - [15:0] latched drops
- Word order: HDR -> PC -> INSN -> RD (only if has_rd) -> MEM (only if has_mem).
  - RD carries rd_wdata; MEM carries mem_addr.
  - Packet length is 3-5 words.
- Handshake:
  - A state advances only on trace_valid_o & trace_ready_i.
  - trace_data_o and trace_last_o hold stable while valid=1 and ready=0.
  - Valid is never withdrawn without a transfer.
- trace_last_o=1 on the final word of each packet.
- On acceptance of the last word:
  - If the FIFO is non-empty, pop and load the next record on the same edge, going directly to HDR with no bubble.
  - Otherwise go to IDLE.
- Latency: a record sampled at edge N has its header valid after edge N+2 when the buffer was empty and IDLE.
- Throughput: one word per cycle with ready held at 1. The sustained rate is 1 retirement per 3-5 cycles; faster retirement fills the FIFO.
- fifo_level_o reflects the registered occupancy.

Test Plan:
- Reset, then retire addi x5 (pc=0x80, insn=0x00A28293, rd_wdata=0x14), ready=1:
  - Expect 4 words: hdr 0xA10A0000, 0x00000080, 0x00A28293, 0x00000014.
  - last=1 on word 4; first word valid 2 cycles after the retire.
- Store (wmask=0xF, addr=0x1000, rd_addr=0), ready=1:
  - Expect 4 words, hdr bits [24:22]=3'b011, final word 0x00001000 with last=1.
- Load to x0 with a trap (trap=1, rmask=0xF, rd_addr=0):
  - Expect hdr bit27=1, has_mem=1, no RD word, 4 words total.
- Depth=8, ready=0, 11 consecutive retirements:
  - Expect level=8, drop_total_o=3.
  - Raise ready: the first header has [16]=1, [15:0]=3; subsequent headers have 0.
- FIFO full while the serializer pops the next record on the same edge as a retirement: expect the push accepted, level unchanged, drop_total_o unchanged.
- Assert rst_ni low while a packet is stalled on its INSN word with ready=0:
  - valid drops to 0 immediately and level=0.
  - The next retirement after reset produces a fresh header.

Source files
------------

// File: rtl/ibex_rvfi_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// ibex_rvfi_trace_buffer_if
// Purpose : 32-bit trace word stream with valid/ready handshake, carrying the
//           serialised retirement packets from ibex_rvfi_trace_buffer to an
//           off-core trace sink (DMA, debug port, testbench monitor).
// Signals : trace_valid_o  word valid        (master -> slave)
//           trace_ready_i  sink ready        (slave  -> master)
//           trace_data_o   32-bit trace word (master -> slave)
//           trace_last_o   final word of the packet (master -> slave)
// Modports: master = the trace buffer, slave = the trace sink.
// -----------------------------------------------------------------------------
interface ibex_rvfi_trace_buffer_if;
   logic        trace_valid_o;
   logic        trace_ready_i;
   logic [31:0] trace_data_o;
   logic        trace_last_o;

   modport master (
      output trace_valid_o,
      output trace_data_o,
      output trace_last_o,
      input  trace_ready_i
   );

   modport slave (
      input  trace_valid_o,
      input  trace_data_o,
      input  trace_last_o,
      output trace_ready_i
   );
endinterface

// File: rtl/ibex_rvfi_trace_buffer.sv
// -----------------------------------------------------------------------------
// ibex_rvfi_trace_buffer
// Purpose : Captures the ibex RVFI retirement stream, queues one record per
//           retired instruction in a small FIFO and serialises each record as
//           a 3-5 word packet (HDR, PC, INSN, [RD], [MEM]) on a valid/ready
//           stream. Records that arrive while the FIFO is full are dropped;
//           the number of drops since the previous header is reported in the
//           next header, and a saturating lifetime total is exported.
// Ports   : clk_i, rst_ni         clock, asynchronous active-low reset
//           rvfi_*                 retirement stream from ibex_top
//           trace (master)         trace word stream (valid/ready/data/last)
//           fifo_level_o           registered FIFO occupancy
//           drop_total_o           saturating lifetime drop count
// Params  : Depth      FIFO entries (power of two, >= 2)
//           SyncNibble header bits [31:28]
// -----------------------------------------------------------------------------
module ibex_rvfi_trace_buffer #(
   parameter int unsigned Depth      = 8,
   parameter logic [3:0]  SyncNibble = 4'hA
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      rvfi_valid,
   input  logic [31:0]               rvfi_insn,
   input  logic                      rvfi_trap,
   input  logic                      rvfi_halt,
   input  logic                      rvfi_intr,
   input  logic [31:0]               rvfi_pc_rdata,
   input  logic [4:0]                rvfi_rd_addr,
   input  logic [31:0]               rvfi_rd_wdata,
   input  logic [31:0]               rvfi_mem_addr,
   input  logic [3:0]                rvfi_mem_rmask,
   input  logic [3:0]                rvfi_mem_wmask,
   ibex_rvfi_trace_buffer_if.master  trace,
   output logic [$clog2(Depth):0]    fifo_level_o,
   output logic [15:0]               drop_total_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned LW = AW + 1;

   typedef struct packed {
      logic        trap;
      logic        intr;
      logic        halt;
      logic        has_rd;
      logic        has_mem;
      logic        is_store;
      logic [4:0]  rd_addr;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] rd_wdata;
      logic [31:0] mem_addr;
   } rec_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_PC   = 3'd2,
      S_INSN = 3'd3,
      S_RD   = 3'd4,
      S_MEM  = 3'd5
   } state_e;

   // Header word: sync nibble, flags, rd, drop indication and latched drop count.
   function automatic logic [31:0] f_hdr(input rec_t r, input logic [15:0] d);
      return {SyncNibble, r.trap, r.intr, r.halt, r.has_rd, r.has_mem,
              r.is_store, r.rd_addr, (d != 16'd0), d};
   endfunction

   rec_t            w_rvfi_rec;
   logic            r_in_valid;
   rec_t            r_in_rec;

   rec_t            r_mem [Depth];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [LW-1:0]   r_level;

   logic [15:0]     r_pending;
   logic [15:0]     r_drop_total;
   logic [15:0]     r_hdr_drops;

   state_e          r_state;
   state_e          w_state_nxt;
   rec_t            r_rec;
   rec_t            w_rec_nxt;
   logic [15:0]     w_hdr_drops_nxt;

   logic            r_valid;
   logic [31:0]     r_data;
   logic            r_last;
   logic            w_valid_nxt;
   logic [31:0]     w_data_nxt;
   logic            w_last_nxt;

   logic            w_fire;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic            w_full_post;

   assign w_rvfi_rec = '{
      trap:     rvfi_trap,
      intr:     rvfi_intr,
      halt:     rvfi_halt,
      has_rd:   (rvfi_rd_addr != 5'd0),
      has_mem:  ((rvfi_mem_rmask | rvfi_mem_wmask) != 4'd0),
      is_store: (rvfi_mem_wmask != 4'd0),
      rd_addr:  rvfi_rd_addr,
      pc:       rvfi_pc_rdata,
      insn:     rvfi_insn,
      rd_wdata: rvfi_rd_wdata,
      mem_addr: rvfi_mem_addr
   };

   assign w_fire = r_valid & trace.trace_ready_i;

   // Full test uses the occupancy after this cycle's pop, so a pop and a push
   // on the same edge never cause a drop.
   assign w_full_post = ((r_level - LW'(w_pop)) == LW'(Depth));
   assign w_push      = r_in_valid & ~w_full_post;
   assign w_drop      = r_in_valid & w_full_post;

   // Input capture stage: one registered copy of the retirement port.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_in_valid <= 1'b0;
         r_in_rec   <= '0;
      end else begin
         r_in_valid <= rvfi_valid;
         if (rvfi_valid) begin
            r_in_rec <= w_rvfi_rec;
         end
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= r_in_rec;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
   end

   // Drop accounting: pending count is handed to the header on every pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pending    <= 16'd0;
         r_drop_total <= 16'd0;
      end else begin
         if (w_pop) begin
            r_pending <= w_drop ? 16'd1 : 16'd0;
         end else if (w_drop && (r_pending != 16'hFFFF)) begin
            r_pending <= r_pending + 16'd1;
         end
         if (w_drop && (r_drop_total != 16'hFFFF)) begin
            r_drop_total <= r_drop_total + 16'd1;
         end
      end
   end

   // Serializer next state; the last word's acceptance pops the next record
   // directly into HDR so back-to-back packets have no bubble.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (r_level != LW'(0)) begin
               w_pop       = 1'b1;
               w_state_nxt = S_HDR;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_HDR: begin
            if (w_fire) begin
               w_state_nxt = S_PC;
            end else begin
               w_state_nxt = S_HDR;
            end
         end
         S_PC: begin
            if (w_fire) begin
               w_state_nxt = S_INSN;
            end else begin
               w_state_nxt = S_PC;
            end
         end
         S_INSN, S_RD, S_MEM: begin
            if (!w_fire) begin
               w_state_nxt = r_state;
            end else if ((r_state == S_INSN) && r_rec.has_rd) begin
               w_state_nxt = S_RD;
            end else if ((r_state != S_MEM) && r_rec.has_mem) begin
               w_state_nxt = S_MEM;
            end else if (r_level != LW'(0)) begin
               w_pop       = 1'b1;
               w_state_nxt = S_HDR;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Record and latched drop count that the next output word is built from.
   always_comb begin
      if (w_pop) begin
         w_rec_nxt       = r_mem[r_rptr];
         w_hdr_drops_nxt = r_pending;
      end else begin
         w_rec_nxt       = r_rec;
         w_hdr_drops_nxt = r_hdr_drops;
      end
   end

   // Next output word, derived from the next state so outputs are registered.
   always_comb begin
      w_valid_nxt = 1'b0;
      w_data_nxt  = 32'h0000_0000;
      w_last_nxt  = 1'b0;
      unique case (w_state_nxt)
         S_IDLE: begin
            w_valid_nxt = 1'b0;
         end
         S_HDR: begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = f_hdr(w_rec_nxt, w_hdr_drops_nxt);
         end
         S_PC: begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_rec_nxt.pc;
         end
         S_INSN: begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_rec_nxt.insn;
            w_last_nxt  = ~w_rec_nxt.has_rd & ~w_rec_nxt.has_mem;
         end
         S_RD: begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_rec_nxt.rd_wdata;
            w_last_nxt  = ~w_rec_nxt.has_mem;
         end
         S_MEM: begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_rec_nxt.mem_addr;
            w_last_nxt  = 1'b1;
         end
         default: begin
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // Serializer state, current record and output word registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_rec       <= '0;
         r_hdr_drops <= 16'd0;
         r_valid     <= 1'b0;
         r_data      <= 32'h0000_0000;
         r_last      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rec       <= w_rec_nxt;
         r_hdr_drops <= w_hdr_drops_nxt;
         r_valid     <= w_valid_nxt;
         r_data      <= w_data_nxt;
         r_last      <= w_last_nxt;
      end
   end

   assign trace.trace_valid_o = r_valid;
   assign trace.trace_data_o  = r_data;
   assign trace.trace_last_o  = r_last;
   assign fifo_level_o        = r_level;
   assign drop_total_o        = r_drop_total;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_ibex_rvfi_trace_buffer
// Directed stimulus drives retirements; each issued retirement pushes its
// expected trace words onto a queue, and a separate monitor pops and compares
// every word the DUT transfers. Level, drop counters, latency and stall
// behaviour are checked directly at chosen points.
// -----------------------------------------------------------------------------
module tb_ibex_rvfi_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        rvfi_valid;
   logic [31:0] rvfi_insn;
   logic        rvfi_trap;
   logic        rvfi_halt;
   logic        rvfi_intr;
   logic [31:0] rvfi_pc_rdata;
   logic [4:0]  rvfi_rd_addr;
   logic [31:0] rvfi_rd_wdata;
   logic [31:0] rvfi_mem_addr;
   logic [3:0]  rvfi_mem_rmask;
   logic [3:0]  rvfi_mem_wmask;
   logic [3:0]  fifo_level;
   logic [15:0] drop_total;

   ibex_rvfi_trace_buffer_if trc ();

   ibex_rvfi_trace_buffer #(.Depth(8), .SyncNibble(4'hA)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .rvfi_valid     (rvfi_valid),
      .rvfi_insn      (rvfi_insn),
      .rvfi_trap      (rvfi_trap),
      .rvfi_halt      (rvfi_halt),
      .rvfi_intr      (rvfi_intr),
      .rvfi_pc_rdata  (rvfi_pc_rdata),
      .rvfi_rd_addr   (rvfi_rd_addr),
      .rvfi_rd_wdata  (rvfi_rd_wdata),
      .rvfi_mem_addr  (rvfi_mem_addr),
      .rvfi_mem_rmask (rvfi_mem_rmask),
      .rvfi_mem_wmask (rvfi_mem_wmask),
      .trace          (trc),
      .fifo_level_o   (fifo_level),
      .drop_total_o   (drop_total)
   );

   always #5 clk = ~clk;

   logic [32:0] exp_q[$];   // {last, data}
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [32:0] mon_exp;

   // Monitor: a word transfers at the next rising edge when valid&ready here.
   always @(negedge clk) begin
      if (rst_ni && trc.trace_valid_o && trc.trace_ready_i) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL word: got data=%h last=%b, required no word", trc.trace_data_o, trc.trace_last_o);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({trc.trace_last_o, trc.trace_data_o} !== mon_exp) begin
               n_bad++;
               $display("FAIL word: got data=%h last=%b, required data=%h last=%b",
                        trc.trace_data_o, trc.trace_last_o, mon_exp[31:0], mon_exp[32]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] mk_hdr(input logic trap, input logic intr, input logic halt,
                                          input logic [4:0] rd, input logic [3:0] rm,
                                          input logic [3:0] wm, input logic [15:0] d);
      return {4'hA, trap, intr, halt, (rd != 5'd0), ((rm | wm) != 4'd0), (wm != 4'd0),
              rd, (d != 16'd0), d};
   endfunction

   task automatic exp_pkt(input logic [31:0] hdr, input logic [31:0] pc, input logic [31:0] insn,
                          input logic has_rd, input logic [31:0] rdw,
                          input logic has_mem, input logic [31:0] maddr);
      exp_q.push_back({1'b0, hdr});
      exp_q.push_back({1'b0, pc});
      exp_q.push_back({(!has_rd && !has_mem), insn});
      if (has_rd) exp_q.push_back({!has_mem, rdw});
      if (has_mem) exp_q.push_back({1'b1, maddr});
   endtask

   // Drives one retirement for exactly one clock; entered and left at posedge+1.
   task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] rdw,
                         input logic [31:0] maddr, input logic [4:0] rd, input logic [3:0] rm,
                         input logic [3:0] wm, input logic trap, input logic intr, input logic halt);
      rvfi_valid     = 1'b1;
      rvfi_pc_rdata  = pc;
      rvfi_insn      = insn;
      rvfi_rd_wdata  = rdw;
      rvfi_mem_addr  = maddr;
      rvfi_rd_addr   = rd;
      rvfi_mem_rmask = rm;
      rvfi_mem_wmask = wm;
      rvfi_trap      = trap;
      rvfi_intr      = intr;
      rvfi_halt      = halt;
      @(posedge clk); #1;
      rvfi_valid     = 1'b0;
   endtask

   task automatic drain();
      int k;
      trc.trace_ready_i = 1'b1;
      k = 0;
      while ((exp_q.size() != 0 || trc.trace_valid_o) && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_words_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_ni = 1'b0;
      trc.trace_ready_i = 1'b0;
      rvfi_valid = 1'b0; rvfi_insn = 32'h0; rvfi_trap = 1'b0; rvfi_halt = 1'b0;
      rvfi_intr = 1'b0; rvfi_pc_rdata = 32'h0; rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'h0;
      rvfi_mem_addr = 32'h0; rvfi_mem_rmask = 4'h0; rvfi_mem_wmask = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, trc.trace_valid_o}, 32'd0);
      chk("rst_data", trc.trace_data_o, 32'h0);
      chk("rst_last", {31'd0, trc.trace_last_o}, 32'd0);
      chk("rst_level", {28'd0, fifo_level}, 32'd0);
      chk("rst_drops", {16'd0, drop_total}, 32'd0);
      rst_ni = 1'b1;
      @(posedge clk); #1;

      // addi x5: 4 words, header valid two edges after the retire edge
      trc.trace_ready_i = 1'b1;
      exp_q.push_back({1'b0, 32'hA10A0000});
      exp_q.push_back({1'b0, 32'h00000080});
      exp_q.push_back({1'b0, 32'h00A28293});
      exp_q.push_back({1'b1, 32'h00000014});
      retire(32'h80, 32'h00A28293, 32'h14, 32'h0, 5'd5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("lat_edge_n", {31'd0, trc.trace_valid_o}, 32'd0);
      @(posedge clk); #1;
      chk("lat_edge_n1", {31'd0, trc.trace_valid_o}, 32'd0);
      @(posedge clk); #1;
      chk("lat_edge_n2", {31'd0, trc.trace_valid_o}, 32'd1);
      chk("lat_hdr", trc.trace_data_o, 32'hA10A0000);
      drain();

      // store: has_mem and is_store set, MEM word last
      exp_q.push_back({1'b0, 32'hA0C00000});
      exp_q.push_back({1'b0, 32'h00000084});
      exp_q.push_back({1'b0, 32'h00B52023});
      exp_q.push_back({1'b1, 32'h00001000});
      retire(32'h84, 32'h00B52023, 32'hDEAD, 32'h1000, 5'd0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
      drain();

      // trapping load to x0: trap bit, has_mem, no RD word
      exp_q.push_back({1'b0, 32'hA8800000});
      exp_q.push_back({1'b0, 32'h00000088});
      exp_q.push_back({1'b0, 32'h00052003});
      exp_q.push_back({1'b1, 32'h00002000});
      retire(32'h88, 32'h00052003, 32'h0, 32'h2000, 5'd0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      drain();

      // overflow: blocker in the serializer, 11 retirements -> 8 queued, 3 dropped
      trc.trace_ready_i = 1'b0;
      exp_q.push_back({1'b0, 32'hA6000000});
      exp_q.push_back({1'b0, 32'h00000100});
      exp_q.push_back({1'b1, 32'h00000013});
      retire(32'h100, 32'h00000013, 32'h0, 32'h0, 5'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 11; i++) begin
         if (i < 8)
            exp_pkt((i == 0) ? 32'hA1030003 : 32'hA1020000, 32'h200 + 32'(4 * i), 32'h00100093,
                    1'b1, 32'(i), 1'b0, 32'h0);
         retire(32'h200 + 32'(4 * i), 32'h00100093, 32'(i), 32'h0, 5'd1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("ovf_level", {28'd0, fifo_level}, 32'd8);
      chk("ovf_drops", {16'd0, drop_total}, 32'd3);
      chk("ovf_stall_hdr", trc.trace_data_o, 32'hA6000000);
      drain();

      // full FIFO, retirement pushed on the same edge as the serializer pop
      trc.trace_ready_i = 1'b0;
      exp_pkt(32'hA0000000, 32'h300, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'h0);
      retire(32'h300, 32'h00000013, 32'h0, 32'h0, 5'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_pkt(mk_hdr(1'b0, 1'b0, 1'b0, 5'd2, 4'h0, 4'h0, 16'd0), 32'h400 + 32'(4 * i),
                 32'h00100113, 1'b1, 32'h100 + 32'(i), 1'b0, 32'h0);
         retire(32'h400 + 32'(4 * i), 32'h00100113, 32'h100 + 32'(i), 32'h0, 5'd2, 4'h0, 4'h0,
                1'b0, 1'b0, 1'b0);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("full_level_pre", {28'd0, fifo_level}, 32'd8);
      exp_q.push_back({1'b0, 32'hA1060000});
      exp_q.push_back({1'b0, 32'h00000500});
      exp_q.push_back({1'b0, 32'h05500193});
      exp_q.push_back({1'b1, 32'h00000055});
      trc.trace_ready_i = 1'b1;
      @(posedge clk); #1;                    // HDR accepted
      retire(32'h500, 32'h05500193, 32'h55, 32'h0, 5'd3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;                    // INSN (last) accepted, pop + push
      trc.trace_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("samedge_level", {28'd0, fifo_level}, 32'd8);
      chk("samedge_drops", {16'd0, drop_total}, 32'd3);
      drain();

      // reset while stalled on the INSN word
      trc.trace_ready_i = 1'b0;
      exp_pkt(32'hA10A0000, 32'h600, 32'h00A28293, 1'b1, 32'h77, 1'b0, 32'h0);
      retire(32'h600, 32'h00A28293, 32'h77, 32'h0, 5'd5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10 && !trc.trace_valid_o; k++) begin
         @(posedge clk); #1;
      end
      chk("stall_valid", {31'd0, trc.trace_valid_o}, 32'd1);
      trc.trace_ready_i = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      trc.trace_ready_i = 1'b0;
      chk("stall_insn", trc.trace_data_o, 32'h00A28293);
      @(posedge clk); #1;
      chk("stall_insn_hold", trc.trace_data_o, 32'h00A28293);
      chk("stall_last_hold", {31'd0, trc.trace_last_o}, 32'd0);
      rst_ni = 1'b0;
      #1;
      chk("arst_valid", {31'd0, trc.trace_valid_o}, 32'd0);
      chk("arst_level", {28'd0, fifo_level}, 32'd0);
      chk("arst_drops", {16'd0, drop_total}, 32'd0);
      chk("arst_words_abandoned", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      @(posedge clk); #1;
      rst_ni = 1'b1;
      @(posedge clk); #1;
      trc.trace_ready_i = 1'b1;
      exp_pkt(32'hA10A0000, 32'h700, 32'h00A28293, 1'b1, 32'h99, 1'b0, 32'h0);
      retire(32'h700, 32'h00A28293, 32'h99, 32'h0, 5'd5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
